// File: rtl/hazard_pkg.sv
// Shared types and pattern constants for the hazard-light pattern decoder.
package hazard_pkg;

  typedef enum logic [1:0] {
    MODE_CALM  = 2'b00,
    MODE_LEFT  = 2'b01,
    MODE_RIGHT = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    STEP_UNIQUE     = 2'd0,
    STEP_AMBIG      = 2'd1,
    STEP_ILL_CODE   = 2'd2,
    STEP_ILL_REPEAT = 2'd3
  } step_e;

  typedef enum logic [1:0] {
    ST_NO_REF = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [2:0] PAT_OUTER = 3'b101;
  localparam logic [2:0] PAT_P0    = 3'b001;
  localparam logic [2:0] PAT_P1    = 3'b010;
  localparam logic [2:0] PAT_P2    = 3'b100;

  // Only the four codes a healthy hazard light ever drives are legal.
  function automatic logic is_legal(input logic [2:0] pat);
    return (pat == PAT_OUTER) || (pat == PAT_P0) || (pat == PAT_P1) || (pat == PAT_P2);
  endfunction

endpackage

// File: rtl/hazard_step_classify.sv
// Combinational classifier: one (prev, cur) pattern step -> step kind and implied mode.
// prev is always a legal code because only legal strobes are ever stored as reference.
module hazard_step_classify
  import hazard_pkg::*;
(
  input  logic [2:0] i_prev,
  input  logic [2:0] i_cur,
  output step_e      o_step,
  output mode_e      o_mode
);

  // Decode the step; mode is only meaningful when the step is unique.
  always_comb begin
    o_step = STEP_ILL_CODE;
    o_mode = MODE_CALM;
    if (!is_legal(i_cur)) begin
      o_step = STEP_ILL_CODE;
    end else if (i_prev == PAT_OUTER) begin
      // Leaving the outer pair: every successor identifies one mode.
      o_step = STEP_UNIQUE;
      case (i_cur)
        PAT_P1:    o_mode = MODE_CALM;
        PAT_OUTER: o_mode = MODE_HOLD;
        PAT_P0:    o_mode = MODE_LEFT;
        default:   o_mode = MODE_RIGHT;
      endcase
    end else if (i_cur == PAT_OUTER) begin
      // Single lamp back to outer pair happens in both CALM and HOLD.
      o_step = STEP_AMBIG;
    end else if (i_cur == i_prev) begin
      o_step = STEP_ILL_REPEAT;
    end else begin
      o_step = STEP_UNIQUE;
      if (((i_prev == PAT_P0) && (i_cur == PAT_P1)) ||
          ((i_prev == PAT_P1) && (i_cur == PAT_P2)) ||
          ((i_prev == PAT_P2) && (i_cur == PAT_P0))) begin
        o_mode = MODE_LEFT;
      end else begin
        o_mode = MODE_RIGHT;
      end
    end
  end

endmodule

// File: rtl/hazard_pattern_decoder.sv
// Monitors the hazard-light LED stream, locks onto the switch mode after CONFIRM
// agreeing steps, flags illegal codes/transitions and drops the lock on timeout.
//
// Handshake: led_valid is a single-cycle strobe with no back-pressure; led is
// sampled on the rising clk edge where led_valid=1 and every output reflects that
// strobe one cycle later.
module hazard_pattern_decoder
  import hazard_pkg::*;
#(
  parameter int CONFIRM        = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       led_valid,
  input  logic [2:0] led,
  output logic [1:0] mode,
  output logic       mode_valid,
  output logic       mode_change,
  output logic       err,
  output logic [7:0] err_count,
  output logic       stale,
  output logic [1:0] dbg_state
);

  localparam int SW = $clog2(CONFIRM + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] CONF_L    = SW'(CONFIRM);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

  state_e        r_state, w_state_n;
  logic [2:0]    r_prev, w_prev_n;
  mode_e         r_cand, w_cand_n;
  logic [SW-1:0] r_streak, w_streak_n;
  mode_e         r_mode, w_mode_n;
  logic          r_mode_valid, w_mode_valid_n;
  logic          r_mode_change, w_mode_change_n;
  logic          r_err, w_err_n;
  logic [7:0]    r_err_count, w_err_count_n;
  logic          r_stale, w_stale_n;
  logic [IW-1:0] r_idle, w_idle_n;

  step_e         w_step;
  mode_e         w_step_mode;

  hazard_step_classify u_classify (
    .i_prev (r_prev),
    .i_cur  (led),
    .o_step (w_step),
    .o_mode (w_step_mode)
  );

  // Next-state, streak, lock, error and idle-timeout logic.
  always_comb begin
    w_state_n       = r_state;
    w_prev_n        = r_prev;
    w_cand_n        = r_cand;
    w_streak_n      = r_streak;
    w_mode_n        = r_mode;
    w_mode_valid_n  = r_mode_valid;
    w_mode_change_n = 1'b0;
    w_err_n         = 1'b0;
    w_err_count_n   = r_err_count;
    w_stale_n       = r_stale;
    w_idle_n        = r_idle;

    if (led_valid) begin
      w_idle_n = '0;
    end else if (r_idle != IDLE_MAX) begin
      w_idle_n = r_idle + IW'(1);
    end

    if (led_valid) begin
      w_stale_n = 1'b0;
      if (r_state == ST_NO_REF) begin
        // First legal code only establishes the reference; no step yet.
        if (is_legal(led)) begin
          w_prev_n  = led;
          w_state_n = ST_TRACK;
        end else begin
          w_err_n = 1'b1;
        end
      end else begin
        case (w_step)
          STEP_ILL_CODE: begin
            w_err_n        = 1'b1;
            w_mode_valid_n = 1'b0;
            w_streak_n     = '0;
            w_state_n      = ST_NO_REF;
          end
          STEP_ILL_REPEAT: begin
            // The repeated code is still legal, so it becomes the new reference.
            w_err_n        = 1'b1;
            w_mode_valid_n = 1'b0;
            w_streak_n     = '0;
            w_prev_n       = led;
            w_state_n      = ST_TRACK;
          end
          STEP_AMBIG: begin
            w_prev_n = led;
          end
          default: begin
            w_prev_n = led;
            if (w_step_mode == r_cand) begin
              w_streak_n = (r_streak == CONF_L) ? CONF_L : r_streak + SW'(1);
            end else begin
              w_cand_n   = w_step_mode;
              w_streak_n = SW'(1);
            end
            // A locked mode only moves once the new candidate is confirmed.
            if (w_streak_n == CONF_L) begin
              w_mode_change_n = !r_mode_valid || (r_mode != w_cand_n);
              w_mode_n        = w_cand_n;
              w_mode_valid_n  = 1'b1;
              w_state_n       = ST_LOCKED;
            end
          end
        endcase
      end
    end else if (r_idle == IDLE_LAST) begin
      // Counter saturates at the limit, so expiry fires once per quiet period.
      w_mode_valid_n = 1'b0;
      w_streak_n     = '0;
      w_stale_n      = 1'b1;
      w_state_n      = ST_NO_REF;
    end

    if (w_err_n && (r_err_count != 8'hFF)) begin
      w_err_count_n = r_err_count + 8'd1;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_NO_REF;
      r_prev        <= PAT_OUTER;
      r_cand        <= MODE_CALM;
      r_streak      <= '0;
      r_mode        <= MODE_CALM;
      r_mode_valid  <= 1'b0;
      r_mode_change <= 1'b0;
      r_err         <= 1'b0;
      r_err_count   <= 8'd0;
      r_stale       <= 1'b0;
      r_idle        <= '0;
    end else begin
      r_state       <= w_state_n;
      r_prev        <= w_prev_n;
      r_cand        <= w_cand_n;
      r_streak      <= w_streak_n;
      r_mode        <= w_mode_n;
      r_mode_valid  <= w_mode_valid_n;
      r_mode_change <= w_mode_change_n;
      r_err         <= w_err_n;
      r_err_count   <= w_err_count_n;
      r_stale       <= w_stale_n;
      r_idle        <= w_idle_n;
    end
  end

  assign mode        = r_mode;
  assign mode_valid  = r_mode_valid;
  assign mode_change = r_mode_change;
  assign err         = r_err;
  assign err_count   = r_err_count;
  assign stale       = r_stale;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_hazard_pattern_decoder.sv
// Directed bench for hazard_pattern_decoder (CONFIRM=2, TIMEOUT_CYCLES=16).
module tb_hazard_pattern_decoder;

  logic       clk;
  logic       reset;
  logic       led_valid;
  logic [2:0] led;
  logic [1:0] mode;
  logic       mode_valid;
  logic       mode_change;
  logic       err;
  logic [7:0] err_count;
  logic       stale;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {mode_valid, mode, mode_change} after each strobe of a sequence.
  logic [3:0] exp_q[$];

  hazard_pattern_decoder #(
    .CONFIRM        (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .led_valid   (led_valid),
    .led         (led),
    .mode        (mode),
    .mode_valid  (mode_valid),
    .mode_change (mode_change),
    .err         (err),
    .err_count   (err_count),
    .stale       (stale),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    led_valid = 1'b0;
    led       = 3'b000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive one strobe; returns on the negedge after the sampling edge.
  task automatic strobe(input logic [2:0] pat);
    @(negedge clk);
    led_valid = 1'b1;
    led       = pat;
    @(negedge clk);
    led_valid = 1'b0;
  endtask

  // Strobe and compare against the next scoreboard entry.
  task automatic strobe_sb(input string tag, input logic [2:0] pat);
    logic [3:0] e;
    strobe(pat);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {mode_valid, mode, mode_change}, e);
    end
  endtask

  task automatic lock_left();
    strobe(3'b001);
    strobe(3'b010);
    strobe(3'b100);
  endtask

  initial begin
    reset     = 1'b1;
    led_valid = 1'b0;
    led       = 3'b000;
    do_reset();

    // Reset state
    check("rst_mode", mode, 2'b00);
    check("rst_valid", mode_valid, 1'b0);
    check("rst_errcnt", err_count, 8'd0);
    check("rst_state", dbg_state, 2'd0);

    // 1: CALM lock through an ambiguous step
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b1001);
    strobe_sb("t1_s1", 3'b101);
    strobe_sb("t1_s2", 3'b010);
    strobe_sb("t1_s3", 3'b101);
    strobe_sb("t1_s4", 3'b010);
    check("t1_err", err, 1'b0);
    @(negedge clk);
    check("t1_change_pulse_end", mode_change, 1'b0);

    // 2: LEFT lock then hysteresis into RIGHT
    do_reset();
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b1011);
    exp_q.push_back(4'b1010);
    exp_q.push_back(4'b1101);
    strobe_sb("t2_s1", 3'b001);
    strobe_sb("t2_s2", 3'b010);
    strobe_sb("t2_s3", 3'b100);
    strobe_sb("t2_s4", 3'b010);
    strobe_sb("t2_s5", 3'b001);
    check("t2_errcnt", err_count, 8'd0);

    // 3: illegal code while locked, then relock
    do_reset();
    lock_left();
    strobe(3'b011);
    check("t3_err", err, 1'b1);
    check("t3_errcnt", err_count, 8'd1);
    check("t3_valid", mode_valid, 1'b0);
    check("t3_mode_held", mode, 2'b01);
    check("t3_state", dbg_state, 2'd0);
    strobe(3'b001);
    check("t3_ref_valid", mode_valid, 1'b0);
    check("t3_ref_err", err, 1'b0);
    strobe(3'b010);
    check("t3_one_step", mode_valid, 1'b0);
    strobe(3'b100);
    check("t3_relock", {mode_valid, mode, mode_change}, 4'b1011);

    // 4: illegal repeat keeps the reference
    do_reset();
    strobe(3'b010);
    strobe(3'b010);
    check("t4_err", err, 1'b1);
    check("t4_valid", mode_valid, 1'b0);
    strobe(3'b100);
    check("t4_one_step", mode_valid, 1'b0);
    strobe(3'b001);
    check("t4_lock", {mode_valid, mode}, 3'b101);
    check("t4_errcnt", err_count, 8'd1);

    // 5: idle timeout, and strobe in the expiry cycle winning
    do_reset();
    lock_left();
    repeat (15) @(negedge clk);
    check("t5_pre_timeout", {mode_valid, stale}, 2'b10);
    @(negedge clk);
    check("t5_timeout", {mode_valid, stale}, 2'b01);
    check("t5_mode_held", mode, 2'b01);
    check("t5_state", dbg_state, 2'd0);
    strobe(3'b001);
    check("t5_stale_clear", {mode_valid, stale}, 2'b00);
    do_reset();
    lock_left();
    repeat (14) @(negedge clk);
    strobe(3'b001);
    check("t5_race", {mode_valid, stale, mode, mode_change}, 5'b10010);

    // 6: async reset mid-lock, then err_count saturation
    do_reset();
    strobe(3'b011);
    lock_left();
    check("t6_pre_lock", {mode_valid, mode}, 3'b101);
    check("t6_pre_errcnt", err_count, 8'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_async_rst", {mode, mode_valid, mode_change, err, err_count, stale}, 14'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    led_valid = 1'b1;
    led       = 3'b011;
    repeat (254) @(negedge clk);
    check("t6_errcnt_254", err_count, 8'd254);
    repeat (46) @(negedge clk);
    led_valid = 1'b0;
    check("t6_errcnt_sat", err_count, 8'd255);
    check("t6_err_last", err, 1'b1);

    if (exp_q.size() != 0) check("leftover_exp", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
